seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  dividend/divisor valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: dividend  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port: divisor  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port: div_by_zero  output  1  result came from a zero divisor.

Function
REQ-013 SHALL implement unsigned radix-2 restoring division: quotient = dividend / divisor, remainder = dividend % divisor.
REQ-014 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 SHALL accept an operation on an edge where in_valid && in_ready, capturing dividend and divisor into internal registers; inputs are ignored at all other edges.
REQ-017 On accept with divisor != 0: IDLE -> BUSY, iteration counter loaded with WIDTH-1, partial remainder cleared.
REQ-018 Each BUSY cycle SHALL perform one iteration: shift {partial remainder, dividend MSB} left by one, trial-subtract divisor in a WIDTH+1-bit subtraction, keep the difference and shift in quotient bit 1 if non-negative, else restore and shift in 0.
REQ-019 On the BUSY cycle with counter == 0: BUSY -> DONE; out_valid SHALL first be high exactly WIDTH cycles after the accepting edge.
REQ-020 On accept with divisor == 0: IDLE -> DONE directly; out_valid high 1 cycle after the accepting edge; quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-021 div_by_zero SHALL be 0 for every non-zero-divisor result.
REQ-022 In DONE, quotient, remainder and div_by_zero SHALL be held stable while out_valid && !out_ready (no limit on stall length).
REQ-023 On an edge in DONE with out_ready = 1: DONE -> IDLE; in_ready high the following cycle (one idle bubble between operations).
REQ-024 SHALL ignore out_ready in IDLE and BUSY, and in_valid in BUSY and DONE.
REQ-025 Edge cases SHALL be exact: dividend < divisor -> quotient 0, remainder = dividend; divisor 1 -> quotient = dividend, remainder 0; dividend 0 -> quotient 0, remainder 0.

Reset
REQ-026 rst high at an edge SHALL force IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, iteration counter = 0.
REQ-027 rst SHALL take priority over all other inputs, including mid-BUSY and mid-DONE stall; the in-flight operation is discarded with no out_valid pulse.
REQ-028 After rst deasserts, in_ready SHALL be 1 on the first cycle and an operation SHALL be accepted on the first edge with in_valid = 1.

Verification
REQ-029 WIDTH=16, dividend=100, divisor=7, out_ready=1 -> out_valid exactly 16 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-030 dividend=0xFFFF, divisor=1, then dividend=3, divisor=10 -> quotient=0xFFFF/remainder=0, then quotient=0/remainder=3.
REQ-031 dividend=5, divisor=0 -> out_valid 1 cycle after accept, quotient=0xFFFF, remainder=5, div_by_zero=1.
REQ-032 dividend=1000, divisor=33, out_ready=0 for 10 cycles after out_valid -> outputs held at quotient=30, remainder=10; in_ready stays 0; DONE exits on the first out_ready edge.
REQ-033 rst pulsed 5 cycles after accepting 0xABCD/0x0012 -> no out_valid, in_ready=1 next cycle; following 9/4 returns quotient=2, remainder=1.
REQ-034 Random unsigned pairs with random in_valid/out_ready throttling, checked against a reference model -> every result matches, exactly one result per accepted operation, in order.

Source files
------------

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, valid/ready on both sides.
// A zero divisor bypasses the iteration and returns all-ones / dividend with div_by_zero set.
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  // The partial remainder stays below the divisor, so the MSB of the
  // WIDTH+1-bit difference is a reliable sign of the trial subtraction.
  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};
  assign q_bit   = ~trial[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      dvd_reg   <= dvd_next;
      dvs_reg   <= dvs_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            dvd_next   = '1;
            rem_next   = dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end else begin
            dvd_next   = dividend;
            dvs_next   = divisor;
            rem_next   = '0;
            dbz_next   = 1'b0;
            count_next = CW'(WIDTH - 1);
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        // dvd_reg doubles as the quotient shift register: dividend bits
        // leave at the top while quotient bits enter at the bottom.
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_next = {dvd_reg[WIDTH-2:0], q_bit};
        if (count_reg == '0) begin
          state_next = DONE;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = dvd_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain-arithmetic expectations.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: present, wait for accept, measure latency, stall, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input int gap);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           exp_lat;
    int           lat;
    int           waitc;
    eq      = (b == 0) ? {W{1'b1}} : a / b;
    er      = (b == 0) ? a : a % b;
    edz     = (b == 0);
    exp_lat = (b == 0) ? 0 : W;

    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b1;
    dividend = $urandom;
    divisor  = $urandom;

    lat = 0;
    while (!out_valid && lat < 100) begin
      out_ready = $urandom_range(0, 1);
      in_valid  = $urandom_range(0, 1);
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    check("in_ready_done", in_ready, 0);

    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = $urandom_range(0, 1);
      dividend  = $urandom;
      divisor   = $urandom;
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_quotient", quotient, eq);
      check("stall_remainder", remainder, er);
      check("stall_dbz", div_by_zero, edz);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    out_ready = 1'b0;
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d stall=%0d",
             a, b, eq, er, edz, lat, stall);
  endtask

  initial begin
    int seen;
    int waitc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // Directed cases, first one accepted on the very first edge after reset.
    run_op(16'd100, 16'd7, 0, 0);
    run_op(16'hFFFF, 16'd1, 0, 0);
    run_op(16'd3, 16'd10, 0, 0);
    run_op(16'd5, 16'd0, 0, 0);
    run_op(16'd1000, 16'd33, 10, 0);
    run_op(16'd0, 16'd9, 0, 1);
    run_op(16'hFFFF, 16'hFFFF, 1, 0);
    run_op(16'h8000, 16'd3, 0, 2);
    run_op(16'd0, 16'd0, 2, 0);

    // Reset five cycles into an iteration.
    in_valid = 1'b1;
    dividend = 16'hABCD;
    divisor  = 16'h0012;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midbusy_rst_ready", in_ready, 1);
    check("midbusy_rst_valid", out_valid, 0);
    check("midbusy_rst_quotient", quotient, 0);
    check("midbusy_rst_remainder", remainder, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("midbusy_no_pulse", seen, 0);
    $display("reset during busy: discarded 0xABCD / 0x0012");
    run_op(16'd9, 16'd4, 0, 0);

    // Reset during a DONE stall.
    in_valid = 1'b1;
    dividend = 16'd20;
    divisor  = 16'd3;
    tick();
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 100) begin
      tick();
      waitc++;
    end
    check("middone_reached", out_valid, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("middone_rst_valid", out_valid, 0);
    check("middone_rst_ready", in_ready, 1);
    check("middone_rst_quotient", quotient, 0);
    check("middone_rst_dbz", div_by_zero, 0);
    $display("reset during done stall: discarded 20 / 3");
    run_op(16'd20, 16'd3, 0, 0);

    // Randomized operands and throttling.
    for (int i = 0; i < 60; i++) begin
      int sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = ra;
        3:       rb = 16'd1;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
